// File: rtl/dino_motion_controller.sv
// Purpose: vertical motion state machine for the runner sprite (run, jump rise/fall, duck, dead).
// Latency: one frame tick -> outputs update on the same clk edge; game_over -> DEAD on the next edge.
// Backpressure: none; up/down are sampled only on the frame tick, outputs are always valid registers.
module dino_motion_controller #(
  parameter int DINO_X  = 50,
  parameter int GROUND  = 335,
  parameter int DINO_H  = 60,
  parameter int JUMP_V  = 14,
  parameter int GRAVITY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        screenEnd,
  input  logic        up,
  input  logic        down,
  input  logic        game_over,
  output logic [31:0] dino_x,
  output logic [31:0] dino_y,
  output logic        airborne,
  output logic        ducking,
  output logic [15:0] jump_count
);

  localparam int          REST_Y   = GROUND - DINO_H;
  localparam logic [31:0] REST_Y_W = 32'(REST_Y);
  localparam logic [7:0]  JUMP_V_W = 8'(JUMP_V);
  localparam logic [7:0]  GRAV_W   = 8'(GRAVITY);

  typedef enum logic [2:0] {
    RUN  = 3'd0,
    RISE = 3'd1,
    FALL = 3'd2,
    DUCK = 3'd3,
    DEAD = 3'd4
  } state_t;

  state_t      state, state_n;
  logic [7:0]  vel, vel_n;
  logic [31:0] y_n;
  logic [15:0] jc_n;
  logic        air_n, duck_n;
  logic        screen_end_q;
  // Set once screenEnd has been seen low after reset, so a frame pulse that
  // straddles reset release cannot masquerade as a fresh rising edge.
  logic        armed;
  logic        tick;
  logic [31:0] fall_sum;
  logic [15:0] jc_sat_inc;

  assign dino_x = 32'(DINO_X);

  assign tick       = screenEnd & ~screen_end_q & armed;
  assign fall_sum   = dino_y + {24'd0, vel} + {24'd0, GRAV_W};
  assign jc_sat_inc = (jump_count == 16'hFFFF) ? jump_count : jump_count + 16'd1;

  // State and datapath registers; reset puts the sprite at rest on the ground.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      dino_y       <= REST_Y_W;
      vel          <= '0;
      screen_end_q <= 1'b0;
      armed        <= 1'b0;
      jump_count   <= '0;
      airborne     <= 1'b0;
      ducking      <= 1'b0;
    end else begin
      state        <= state_n;
      dino_y       <= y_n;
      vel          <= vel_n;
      screen_end_q <= screenEnd;
      armed        <= armed | ~screenEnd;
      jump_count   <= jc_n;
      airborne     <= air_n;
      ducking      <= duck_n;
    end
  end

  // Next-state and motion update; game_over overrides and discards any tick.
  always_comb begin
    state_n = state;
    y_n     = dino_y;
    vel_n   = vel;
    jc_n    = jump_count;

    if (game_over) begin
      state_n = DEAD;
    end else if (tick) begin
      case (state)
        RUN: begin
          if (up) begin
            state_n = RISE;
            vel_n   = JUMP_V_W;
            jc_n    = jc_sat_inc;
          end else if (down) begin
            state_n = DUCK;
          end
        end
        RISE: begin
          // vel never exceeds the height already climbable, so no underflow.
          y_n = dino_y - {24'd0, vel};
          if (down || (vel <= GRAV_W)) begin
            state_n = FALL;
            vel_n   = '0;
          end else begin
            vel_n = vel - GRAV_W;
          end
        end
        FALL: begin
          if (fall_sum >= REST_Y_W) begin
            state_n = RUN;
            y_n     = REST_Y_W;
            vel_n   = '0;
          end else begin
            y_n   = fall_sum;
            vel_n = vel + GRAV_W;
          end
        end
        DUCK: begin
          y_n = REST_Y_W;
          if (down) begin
            state_n = DUCK;
          end else if (up) begin
            state_n = RISE;
            vel_n   = JUMP_V_W;
            jc_n    = jc_sat_inc;
          end else begin
            state_n = RUN;
          end
        end
        default: begin
          state_n = state;
        end
      endcase
    end

    // Flags follow the next state, but freeze at their entry value once dead.
    if (state_n == DEAD) begin
      air_n  = airborne;
      duck_n = ducking;
    end else begin
      air_n  = (state_n == RISE) || (state_n == FALL);
      duck_n = (state_n == DUCK);
    end
  end

endmodule

// File: tb/tb_dino_motion_controller.sv
// Purpose: scoreboard bench for dino_motion_controller with directed frame vectors.
// Latency: expected frame results are queued at stimulus time, popped one frame tick later.
// Backpressure: none; the monitor samples on the negedge after each frame's tick edge.
module tb_dino_motion_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        screenEnd = 1'b0;
  logic        up = 1'b0;
  logic        down = 1'b0;
  logic        game_over = 1'b0;
  logic [31:0] dino_x;
  logic [31:0] dino_y;
  logic        airborne;
  logic        ducking;
  logic [15:0] jump_count;

  typedef struct {
    int y;
    bit air;
    bit duck;
    int jc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   frame_no = 0;

  // Full default jump: launch tick, 14 rise ticks to the apex, 14 fall ticks.
  int jump_y [29] = '{275, 261, 248, 236, 225, 215, 206, 198, 191, 185, 180, 176, 173, 171, 170,
                      171, 173, 176, 180, 185, 191, 198, 206, 215, 225, 236, 248, 261, 275};
  // Rise aborted by down at 215 -> 206, then free fall from zero velocity.
  int abort_y [12] = '{207, 209, 212, 216, 221, 227, 234, 242, 251, 261, 272, 275};

  always #5 clk = ~clk;

  dino_motion_controller dut (
    .clk        (clk),
    .reset      (reset),
    .screenEnd  (screenEnd),
    .up         (up),
    .down       (down),
    .game_over  (game_over),
    .dino_x     (dino_x),
    .dino_y     (dino_y),
    .airborne   (airborne),
    .ducking    (ducking),
    .jump_count (jump_count)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // One frame: queue the expected result, then raise screenEnd for len cycles.
  task automatic frame(input bit u, input bit d, input bit g, input int len,
                       input int ey, input bit ea, input bit ed, input int ejc);
    exp_t e;
    e.y = ey; e.air = ea; e.duck = ed; e.jc = ejc;
    exp_q.push_back(e);
    up = u; down = d; game_over = g; screenEnd = 1'b1;
    @(negedge clk);
    game_over = 1'b0;
    repeat (len - 1) @(negedge clk);
    screenEnd = 1'b0; up = 1'b0; down = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Monitor: every screenEnd rise outside reset is one frame result to compare.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge screenEnd);
      if (reset) continue;
      @(posedge clk);
      @(negedge clk);
      frame_no++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard_underflow frame %0d: queue size 0, expected an entry", frame_no);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("f%0d_y", frame_no), dino_y, e.y);
        check($sformatf("f%0d_air", frame_no), airborne, e.air);
        check($sformatf("f%0d_duck", frame_no), ducking, e.duck);
        check($sformatf("f%0d_jc", frame_no), jump_count, e.jc);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    // Asynchronous reset with no clock edge involved.
    #1 reset = 1'b1;
    #1;
    check("rst_y", dino_y, 275);
    check("rst_x", dino_x, 50);
    check("rst_air", airborne, 0);
    check("rst_duck", ducking, 0);
    check("rst_jc", jump_count, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Full jump; the fifth frame uses a 100-cycle screenEnd pulse.
    for (int i = 0; i < 29; i++)
      frame(i == 0, 1'b0, 1'b0, (i == 4) ? 100 : 4, jump_y[i], i < 28, 1'b0, 1);

    // Idle frame, then ducking (up ignored while down held), then DUCK + up launches.
    frame(0, 0, 0, 4, 275, 0, 0, 1);
    frame(0, 1, 0, 4, 275, 0, 1, 1);
    frame(1, 1, 0, 4, 275, 0, 1, 1);
    frame(0, 1, 0, 6, 275, 0, 1, 1);
    frame(0, 0, 0, 4, 275, 0, 0, 1);
    frame(0, 1, 0, 4, 275, 0, 1, 1);
    frame(1, 0, 0, 4, 275, 1, 0, 2);

    // Rise to 215, abort with down, free fall back to rest.
    frame(0, 0, 0, 4, 261, 1, 0, 2);
    frame(0, 0, 0, 4, 248, 1, 0, 2);
    frame(0, 0, 0, 4, 236, 1, 0, 2);
    frame(0, 0, 0, 4, 225, 1, 0, 2);
    frame(0, 0, 0, 4, 215, 1, 0, 2);
    frame(0, 1, 0, 4, 206, 1, 0, 2);
    for (int i = 0; i < 12; i++)
      frame(0, 0, 0, 4, abort_y[i], i < 11, 0, 2);

    // up and down together in RUN launch; fall to 176 then die on a tick.
    frame(1, 1, 0, 4, 275, 1, 0, 3);
    for (int i = 1; i < 18; i++)
      frame(0, 0, 0, 4, jump_y[i], 1, 0, 3);
    frame(0, 0, 1, 4, 176, 1, 0, 3);
    for (int i = 0; i < 10; i++)
      frame(1, 0, 0, 4, 176, 1, 0, 3);

    // Reset out of DEAD with screenEnd and up already high across release.
    reset = 1'b1;
    screenEnd = 1'b1; up = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("stale_pulse_y", dino_y, 275);
    check("stale_pulse_air", airborne, 0);
    check("stale_pulse_jc", jump_count, 0);
    screenEnd = 1'b0; up = 1'b0;
    repeat (3) @(negedge clk);

    // Jump to the apex, then assert reset between clock edges.
    for (int i = 0; i < 15; i++)
      frame(i == 0, 1'b0, 1'b0, 4, jump_y[i], 1, 1'b0, 1);
    #2 reset = 1'b1;
    #1;
    check("apex_rst_y", dino_y, 275);
    check("apex_rst_air", airborne, 0);
    check("apex_rst_jc", jump_count, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // No residual velocity after release; a fresh jump starts cleanly.
    frame(0, 0, 0, 4, 275, 0, 0, 0);
    frame(1, 0, 0, 4, 275, 1, 0, 1);
    frame(0, 0, 0, 4, 261, 1, 0, 1);

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
